// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath enable and mux select.
module multicycle_control #(
  parameter int ALU_OP_W      = 2,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit EN_ADDI       = 1'b1,
  parameter bit EN_JUMP       = 1'b1,
  parameter int TIMEOUT       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          instr_op,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          pc_source,
  output logic                illegal,
  output logic                mem_timeout,
  output logic [3:0]          state
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit COUNT_EN = MEM_HANDSHAKE && (TIMEOUT > 0);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EXEC   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_I_EXEC   = 4'd10;
  localparam logic [3:0] S_I_WB     = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic [3:0]       cur_state;
  logic [3:0]       next_state;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             ready_eff;
  logic             in_mem_state;
  logic             next_is_mem;
  logic             timed_out;
  logic [3:0]       decode_next;

  // An opcode that maps back to FETCH is by definition unsupported.
  function automatic logic [3:0] decode_target(input logic [5:0] op);
    case (op)
      OP_R:         return S_R_EXEC;
      OP_LW, OP_SW: return S_MEM_ADDR;
      OP_BEQ:       return S_BRANCH;
      OP_J:         return EN_JUMP ? S_JUMP : S_FETCH;
      OP_ADDI:      return EN_ADDI ? S_I_EXEC : S_FETCH;
      default:      return S_FETCH;
    endcase
  endfunction

  function automatic logic is_mem(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  assign ready_eff    = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign in_mem_state = is_mem(cur_state);
  assign next_is_mem  = is_mem(next_state);
  assign decode_next  = decode_target(instr_op);

  // A ready in the same cycle as the limit wins, so the timeout requires mem_ready low.
  always_comb begin
    timed_out = 1'b0;
    if (COUNT_EN)
      timed_out = in_mem_state && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT));
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_FETCH:    if (ready_eff) next_state = S_DECODE;
                  else if (timed_out) next_state = S_FETCH;
      S_DECODE:   next_state = decode_next;
      S_MEM_ADDR: next_state = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (ready_eff) next_state = S_MEM_WB;
                  else if (timed_out) next_state = S_FETCH;
      S_MEM_WR:   if (ready_eff || timed_out) next_state = S_FETCH;
      S_R_EXEC:   next_state = S_R_WB;
      S_I_EXEC:   next_state = S_I_WB;
      default:    next_state = S_FETCH;
    endcase
  end

  // Wait counter restarts on every entry into a memory state, including a timeout re-fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_FETCH;
      op_q      <= '0;
      wait_cnt  <= '0;
    end else begin
      cur_state <= next_state;
      if (cur_state == S_DECODE)
        op_q <= instr_op;
      if (!COUNT_EN)
        wait_cnt <= '0;
      else if (next_is_mem && ((next_state != cur_state) || timed_out))
        wait_cnt <= '0;
      else if (in_mem_state && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = '0;
    pc_source     = 2'b00;
    illegal       = 1'b0;
    mem_timeout   = 1'b0;
    state         = 4'd0;
    if (!rst) begin
      state       = cur_state;
      mem_timeout = timed_out;
      case (cur_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = ready_eff;
          pc_write  = ready_eff;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          illegal   = (decode_next == S_FETCH);
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = !timed_out;
          i_or_d    = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_OP_W'(2'b10);
        end
        S_R_WB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_OP_W'(2'b01);
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_I_WB: reg_write = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a handshaking instance (TIMEOUT=4) and a no-handshake instance
// without ADDI/J share one stimulus stream and are compared against an instruction-path model.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  instr_op = 6'd0;
  logic        mem_ready = 1'b1;
  wire  [21:0] v0;
  wire  [21:0] v1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Vector layout: pcw pcwc irw iord mrd mwr rdst rw m2r asa asb[2] aop[2] psrc[2] ill tmo state[4]
  multicycle_control #(.ALU_OP_W(2), .MEM_HANDSHAKE(1'b1), .EN_ADDI(1'b1), .EN_JUMP(1'b1), .TIMEOUT(4)) dut0 (
    .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready),
    .pc_write(v0[21]), .pc_write_cond(v0[20]), .ir_write(v0[19]), .i_or_d(v0[18]),
    .mem_read(v0[17]), .mem_write(v0[16]), .reg_dst(v0[15]), .reg_write(v0[14]),
    .mem_to_reg(v0[13]), .alu_src_a(v0[12]), .alu_src_b(v0[11:10]), .alu_op(v0[9:8]),
    .pc_source(v0[7:6]), .illegal(v0[5]), .mem_timeout(v0[4]), .state(v0[3:0])
  );

  multicycle_control #(.ALU_OP_W(2), .MEM_HANDSHAKE(1'b0), .EN_ADDI(1'b0), .EN_JUMP(1'b0), .TIMEOUT(16)) dut1 (
    .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready),
    .pc_write(v1[21]), .pc_write_cond(v1[20]), .ir_write(v1[19]), .i_or_d(v1[18]),
    .mem_read(v1[17]), .mem_write(v1[16]), .reg_dst(v1[15]), .reg_write(v1[14]),
    .mem_to_reg(v1[13]), .alu_src_a(v1[12]), .alu_src_b(v1[11:10]), .alu_op(v1[9:8]),
    .pc_source(v1[7:6]), .illegal(v1[5]), .mem_timeout(v1[4]), .state(v1[3:0])
  );

  bit HS[2]   = '{1'b1, 1'b0};
  int TO[2]   = '{4, 16};
  bit ADDI[2] = '{1'b1, 1'b0};
  bit JMP[2]  = '{1'b1, 1'b0};

  int         mst[2];
  int         mcnt[2];
  int         mpos[2];
  logic [5:0] mop[2];
  bit         model_ok = 1'b0;

  // Post-decode path of an instruction as a list of states; past its end the machine re-fetches.
  function automatic int path_at(input logic [5:0] op, input bit addi, input bit jmp, input int idx);
    int p[3];
    int n;
    p = '{0, 0, 0};
    n = 0;
    case (op)
      6'b000000: begin p[0] = 6;  p[1] = 7;  n = 2; end
      6'b100011: begin p[0] = 2;  p[1] = 3;  p[2] = 4; n = 3; end
      6'b101011: begin p[0] = 2;  p[1] = 5;  n = 2; end
      6'b000100: begin p[0] = 8;  n = 1; end
      6'b000010: if (jmp)  begin p[0] = 9;  n = 1; end
      6'b001000: if (addi) begin p[0] = 10; p[1] = 11; n = 2; end
      default: n = 0;
    endcase
    return (idx < n) ? p[idx] : 0;
  endfunction

  function automatic bit is_mem(input int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  function automatic bit tmo_now(input int k, input int s, input int cnt, input bit mr);
    return HS[k] && (TO[k] > 0) && is_mem(s) && !mr && (cnt == TO[k]);
  endfunction

  function automatic logic [21:0] expect_vec(input int k, input int s, input bit r, input bit mr,
                                             input int cnt, input logic [5:0] op);
    logic [21:0] e;
    bit rdy;
    bit tmo;
    e = '0;
    if (r) return e;
    rdy = HS[k] ? mr : 1'b1;
    tmo = tmo_now(k, s, cnt, mr);
    e[3:0] = 4'(s);
    e[4]   = tmo;
    case (s)
      0:  begin e[17] = 1'b1; e[11:10] = 2'b01; e[19] = rdy; e[21] = rdy; end
      1:  begin e[11:10] = 2'b11; e[5] = (path_at(op, ADDI[k], JMP[k], 0) == 0); end
      2:  begin e[12] = 1'b1; e[11:10] = 2'b10; end
      3:  begin e[17] = 1'b1; e[18] = 1'b1; end
      4:  begin e[14] = 1'b1; e[13] = 1'b1; end
      5:  begin e[16] = !tmo; e[18] = 1'b1; end
      6:  begin e[12] = 1'b1; e[9:8] = 2'b10; end
      7:  begin e[15] = 1'b1; e[14] = 1'b1; end
      8:  begin e[12] = 1'b1; e[9:8] = 2'b01; e[20] = 1'b1; e[7:6] = 2'b01; end
      9:  begin e[21] = 1'b1; e[7:6] = 2'b10; end
      10: begin e[12] = 1'b1; e[11:10] = 2'b10; end
      11: e[14] = 1'b1;
      default: e = '1;
    endcase
    return e;
  endfunction

  // Model advances on the same edge as the DUTs, using the inputs held over that edge.
  int t_nxt;
  int t_pos;
  bit t_tmo;
  bit t_rdy;
  always @(posedge clk) begin
    if (rst) model_ok <= 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mst[k]  <= 0;
        mcnt[k] <= 0;
        mpos[k] <= 0;
        mop[k]  <= 6'd0;
      end else begin
        t_rdy = HS[k] ? mem_ready : 1'b1;
        t_tmo = tmo_now(k, mst[k], mcnt[k], mem_ready);
        t_pos = mpos[k];
        if (is_mem(mst[k]) && t_tmo)
          t_nxt = 0;
        else if (is_mem(mst[k]) && !t_rdy)
          t_nxt = mst[k];
        else if (mst[k] == 0)
          t_nxt = 1;
        else if (mst[k] == 1) begin
          mop[k] <= instr_op;
          t_pos = 0;
          t_nxt = path_at(instr_op, ADDI[k], JMP[k], 0);
        end else begin
          t_pos = mpos[k] + 1;
          t_nxt = path_at(mop[k], ADDI[k], JMP[k], t_pos);
        end
        if (is_mem(t_nxt) && ((t_nxt != mst[k]) || t_tmo))
          mcnt[k] <= 0;
        else if (HS[k] && is_mem(mst[k]) && !mem_ready)
          mcnt[k] <= mcnt[k] + 1;
        mpos[k] <= t_pos;
        mst[k]  <= t_nxt;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("model_dut0", 32'(v0), 32'(expect_vec(0, mst[0], rst, mem_ready, mcnt[0], instr_op)));
      checkOutput("model_dut1", 32'(v1), 32'(expect_vec(1, mst[1], rst, mem_ready, mcnt[1], instr_op)));
    end
  end

  task automatic applyStimulus(input bit r, input bit m, input logic [5:0] op);
    @(posedge clk);
    #1;
    rst       = r;
    mem_ready = m;
    instr_op  = op;
    @(negedge clk);
  endtask

  logic [5:0] op_table[8];
  int         low_burst;
  bit         r_bit;
  bit         m_bit;
  logic [5:0] op_pick;

  initial begin
    op_table = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b111111, 6'b100011};

    applyStimulus(1, 1, 6'd0);
    applyStimulus(1, 1, 6'd0);
    checkOutput("reset_zero_dut0", 32'(v0), 32'd0);
    checkOutput("reset_zero_dut1", 32'(v1), 32'd0);

    applyStimulus(0, 1, 6'd0);
    checkOutput("fetch_state", 32'(v0[3:0]), 32'd0);
    checkOutput("fetch_rd_pcw", 32'({v0[21], v0[19], v0[17]}), 32'b111);

    applyStimulus(0, 1, 6'b000000);
    checkOutput("r_decode", 32'({v0[3:0], v0[11:10]}), 32'({4'd1, 2'b11}));
    applyStimulus(0, 1, 6'd0);
    checkOutput("r_exec", 32'({v0[3:0], v0[9:8], v0[14]}), 32'({4'd6, 2'b10, 1'b0}));
    applyStimulus(0, 1, 6'd0);
    checkOutput("r_wb", 32'({v0[3:0], v0[15], v0[14]}), 32'({4'd7, 2'b11}));
    applyStimulus(0, 1, 6'd0);
    checkOutput("r_back_fetch", 32'(v0[3:0]), 32'd0);

    applyStimulus(0, 1, 6'b100011);
    applyStimulus(0, 0, 6'd0);
    checkOutput("lw_addr", 32'(v0[3:0]), 32'd2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, (i == 3), 6'd0);
      checkOutput("lw_rd_hold", 32'(v0[3:0]), 32'd3);
    end
    applyStimulus(0, 1, 6'd0);
    checkOutput("lw_wb", 32'({v0[3:0], v0[14], v0[13]}), 32'({4'd4, 2'b11}));
    applyStimulus(0, 1, 6'd0);
    checkOutput("lw_back_fetch", 32'(v0[3:0]), 32'd0);

    applyStimulus(0, 1, 6'b101011);
    applyStimulus(0, 0, 6'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 6'd0);
      checkOutput("sw_wait", 32'({v0[3:0], v0[16], v0[4]}), 32'({4'd5, 2'b10}));
    end
    applyStimulus(0, 0, 6'd0);
    checkOutput("sw_timeout", 32'({v0[3:0], v0[16], v0[4]}), 32'({4'd5, 2'b01}));
    applyStimulus(0, 1, 6'd0);
    checkOutput("sw_timeout_fetch", 32'({v0[3:0], v0[4]}), 32'd0);

    applyStimulus(0, 1, 6'b101011);
    applyStimulus(0, 0, 6'd0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 6'd0);
    applyStimulus(0, 1, 6'd0);
    checkOutput("sw_late_ready", 32'({v0[3:0], v0[16], v0[4]}), 32'({4'd5, 2'b10}));
    applyStimulus(0, 1, 6'd0);
    checkOutput("sw_done_fetch", 32'(v0[3:0]), 32'd0);

    applyStimulus(0, 1, 6'b000100);
    applyStimulus(0, 1, 6'd0);
    checkOutput("beq", 32'({v0[3:0], v0[20], v0[7:6], v0[9:8]}), 32'({4'd8, 1'b1, 2'b01, 2'b01}));
    applyStimulus(0, 1, 6'b000010);
    checkOutput("beq_3cyc_fetch", 32'(v0[3:0]), 32'd0);
    applyStimulus(0, 1, 6'b000010);
    applyStimulus(0, 1, 6'd0);
    checkOutput("jump", 32'({v0[3:0], v0[21], v0[7:6]}), 32'({4'd9, 1'b1, 2'b10}));
    applyStimulus(0, 1, 6'd0);

    applyStimulus(0, 1, 6'b111111);
    checkOutput("illegal_pulse", 32'({v0[3:0], v0[5], v0[21], v0[19], v0[16], v0[14]}), 32'({4'd1, 5'b10000}));
    applyStimulus(0, 1, 6'd0);
    checkOutput("illegal_fetch", 32'({v0[3:0], v0[5]}), 32'd0);

    applyStimulus(1, 1, 6'd0);
    applyStimulus(0, 1, 6'd0);
    applyStimulus(0, 1, 6'b001000);
    checkOutput("addi_legal_dut0", 32'(v0[5]), 32'd0);
    checkOutput("addi_illegal_dut1", 32'({v1[3:0], v1[5]}), 32'({4'd1, 1'b1}));
    applyStimulus(0, 1, 6'd0);
    checkOutput("addi_exec_dut0", 32'(v0[3:0]), 32'd10);
    checkOutput("addi_fetch_dut1", 32'(v1[3:0]), 32'd0);

    low_burst = 0;
    for (int c = 0; c < 3000; c++) begin
      r_bit = ($urandom_range(0, 79) == 0);
      if (low_burst == 0 && $urandom_range(0, 39) == 0) low_burst = $urandom_range(3, 7);
      if (low_burst > 0) begin
        m_bit = 1'b0;
        low_burst--;
      end else begin
        m_bit = ($urandom_range(0, 9) < 7);
      end
      op_pick = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_table[$urandom_range(0, 7)];
      applyStimulus(r_bit, m_bit, op_pick);
    end

    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
